// File: rtl/wb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// wb_flush_ctrl
//   Pipeline recovery sequencer for exceptions and ERTN committed in WB.
//   For each accepted event it issues one CSR commit strobe, flushes IF..MEM,
//   redirects fetch to the exception entry (exception) or ERA (ERTN) through
//   a valid/ready handshake, and keeps WB closed until a fixed drain window
//   after the redirect has been accepted.
//
// Parameters
//   DRAIN_CYCLES  cycles flush stays high after the redirect handshake (>=1)
//   CNT_W         width of the saturating accepted-event counter
//
// Ports
//   clk             clock
//   reset           asynchronous reset, active-high
//   wb_valid        WB holds a valid instruction
//   wb_ex           WB instruction raises an exception (incl. interrupt)
//   wb_ertn         WB instruction is ERTN
//   csr_eentry      exception entry address
//   csr_era         exception return address
//   redirect_ready  IF accepts the redirect this cycle
//   csr_commit      1-cycle strobe: CSR latches ex/ertn side effects
//   csr_commit_ertn kind of the commit: 1 = ERTN, 0 = exception
//   flush           kill all in-flight instructions in IF..MEM
//   redirect_valid  redirect request to IF
//   redirect_pc     new fetch PC
//   wb_block        1 = WB refuses new instructions
//   flush_cnt       number of accepted events, saturating
// ---------------------------------------------------------------------------
module wb_flush_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic             wb_ex,
  input  logic             wb_ertn,
  input  logic [31:0]      csr_eentry,
  input  logic [31:0]      csr_era,
  input  logic             redirect_ready,
  output logic             csr_commit,
  output logic             csr_commit_ertn,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             wb_block,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // Drain counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [DRN_W-1:0] drain_cnt;

  logic wb_event;
  logic accept;
  logic handshake;

  assign wb_event  = wb_valid & (wb_ex | wb_ertn);
  // Events are only looked at in IDLE; anything arriving mid-sequence is dropped.
  assign accept    = (state == IDLE) & wb_event;
  assign handshake = (state == REDIRECT) & redirect_ready;

  // Next state and outputs. Outputs are decoded from the state register only,
  // so none of them has a combinational path from an input.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_state     = state;
    csr_commit     = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    wb_block       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) next_state = COMMIT;
      end
      COMMIT: begin
        csr_commit = 1'b1;
        flush      = 1'b1;
        wb_block   = 1'b1;
        next_state = REDIRECT;
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        wb_block       = 1'b1;
        if (redirect_ready) next_state = DRAIN;
      end
      DRAIN: begin
        flush    = 1'b1;
        wb_block = 1'b1;
        if (drain_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Target, kind and counters. Target and kind are captured only on accept,
  // so they stay stable through the redirect handshake and afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc     <= '0;
      csr_commit_ertn <= 1'b0;
      flush_cnt       <= '0;
      drain_cnt       <= '0;
    end else begin
      if (accept) begin
        // Exception wins when both wb_ex and wb_ertn are set.
        redirect_pc     <= wb_ex ? csr_eentry : csr_era;
        csr_commit_ertn <= ~wb_ex;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (handshake)
        drain_cnt <= DRAIN_LOAD;
      else if ((state == DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DRN_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_flush_ctrl
//   Directed bench for wb_flush_ctrl. Main instance uses default parameters;
//   a second instance with CNT_W=2 exercises counter saturation.
//   Outputs are sampled 1 time unit after the rising edge; inputs are driven
//   at the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_wb_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ex, wb_ertn;
  logic [31:0] csr_eentry, csr_era;
  logic        redirect_ready;
  logic        csr_commit, csr_commit_ertn, flush, redirect_valid, wb_block;
  logic [31:0] redirect_pc;
  logic [15:0] flush_cnt;

  // Saturation instance signals
  logic        s_wb_valid;
  logic        s_csr_commit, s_csr_commit_ertn, s_flush, s_redirect_valid, s_wb_block;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Output flag vectors: {csr_commit, flush, redirect_valid, wb_block}
  localparam logic [3:0] F_IDLE     = 4'b0000;
  localparam logic [3:0] F_COMMIT   = 4'b1101;
  localparam logic [3:0] F_REDIRECT = 4'b0111;
  localparam logic [3:0] F_DRAIN    = 4'b0101;

  always #5 clk = ~clk;

  wb_flush_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .redirect_ready(redirect_ready),
    .csr_commit(csr_commit), .csr_commit_ertn(csr_commit_ertn),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .wb_block(wb_block), .flush_cnt(flush_cnt)
  );

  wb_flush_ctrl #(.DRAIN_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .wb_valid(s_wb_valid), .wb_ex(1'b1), .wb_ertn(1'b0),
    .csr_eentry(32'h0000_4000), .csr_era(32'h0000_8000),
    .redirect_ready(1'b1),
    .csr_commit(s_csr_commit), .csr_commit_ertn(s_csr_commit_ertn),
    .flush(s_flush), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .wb_block(s_wb_block), .flush_cnt(s_flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {csr_commit, flush, redirect_valid, wb_block};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: {commit,flush,rv,block} got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    tests_run++;
    if (redirect_pc !== exp) begin
      tests_failed++;
      $display("FAIL %s: redirect_pc got %h expected %h", name, redirect_pc, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] exp);
    tests_run++;
    if (flush_cnt !== exp) begin
      tests_failed++;
      $display("FAIL %s: flush_cnt got %0d expected %0d", name, flush_cnt, exp);
    end
  endtask

  task automatic chk_ertn(input string name, input logic exp);
    tests_run++;
    if (csr_commit_ertn !== exp) begin
      tests_failed++;
      $display("FAIL %s: csr_commit_ertn got %b expected %b", name, csr_commit_ertn, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); s_wb_valid = 1'b0;
    csr_eentry = '0; csr_era = '0; redirect_ready = 1'b0;
    step(); step();
    chk_flags("reset_flags", F_IDLE);
    chk_pc("reset_pc", 32'h0);
    chk_cnt("reset_cnt", 16'd0);
    chk_ertn("reset_ertn", 1'b0);
    #2 reset = 1'b0;
    step();
    chk_flags("post_reset_idle", F_IDLE);
  endtask

  // T1: exception, ready high throughout
  task automatic test_exception();
    wb_valid = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1C00_8000;
    csr_era = 32'hDEAD_BEEF; redirect_ready = 1'b1;
    step();                                   // t1
    idle_inputs(); csr_eentry = 32'h0BAD_0BAD; // target must already be latched
    chk_flags("ex_t1_commit", F_COMMIT);
    chk_pc("ex_t1_pc", 32'h1C00_8000);
    chk_ertn("ex_t1_kind", 1'b0);
    chk_cnt("ex_t1_cnt", 16'd1);
    step(); chk_flags("ex_t2_redirect", F_REDIRECT);
    chk_pc("ex_t2_pc", 32'h1C00_8000);
    step(); chk_flags("ex_t3_drain", F_DRAIN);
    step(); chk_flags("ex_t4_drain", F_DRAIN);
    step(); chk_flags("ex_t5_idle", F_IDLE);
    chk_cnt("ex_t5_cnt", 16'd1);
  endtask

  // T2: ERTN, IF not ready for 5 cycles
  task automatic test_ertn_stall();
    int commits;
    commits = 0;
    wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_0104;
    csr_eentry = 32'h1111_1111; redirect_ready = 1'b0;
    step();                                   // t1
    idle_inputs(); csr_era = 32'h2222_2222;
    chk_flags("ertn_t1_commit", F_COMMIT);
    chk_ertn("ertn_t1_kind", 1'b1);
    if (csr_commit) commits++;
    step();                                   // t2
    for (int i = 0; i < 6; i++) begin
      chk_flags($sformatf("ertn_hold%0d", i), F_REDIRECT);
      chk_pc($sformatf("ertn_hold_pc%0d", i), 32'h1C00_0104);
      if (csr_commit) commits++;
      if (i == 5) redirect_ready = 1'b1;
      step();
    end
    redirect_ready = 1'b0;                    // drain must not care about ready
    chk_flags("ertn_drain0", F_DRAIN);
    step(); chk_flags("ertn_drain1", F_DRAIN);
    step(); chk_flags("ertn_idle", F_IDLE);
    chk_ertn("ertn_kind_kept", 1'b1);
    chk_cnt("ertn_cnt", 16'd2);
    tests_run++;
    if (commits !== 1) begin
      tests_failed++;
      $display("FAIL ertn_commit_once: pulses got %0d expected 1", commits);
    end
  endtask

  // T3: wb_ex and wb_ertn together -> exception
  task automatic test_both();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ertn = 1'b1;
    csr_eentry = 32'hAAAA_0000; csr_era = 32'h5555_0000; redirect_ready = 1'b1;
    step(); idle_inputs();
    chk_flags("both_commit", F_COMMIT);
    chk_pc("both_pc", 32'hAAAA_0000);
    chk_ertn("both_kind", 1'b0);
    chk_cnt("both_cnt", 16'd3);
    step(); step(); step(); step();
    chk_flags("both_idle", F_IDLE);
  endtask

  // T4: event held through the whole sequence
  task automatic test_ignore();
    wb_valid = 1'b1; wb_ex = 1'b1; csr_eentry = 32'h1234_0000; redirect_ready = 1'b1;
    step();                                   // t1 COMMIT
    csr_eentry = 32'h9999_0000;               // event stays asserted
    chk_cnt("ign_t1_cnt", 16'd4);
    step(); chk_flags("ign_t2_redirect", F_REDIRECT);
    step(); chk_flags("ign_t3_drain", F_DRAIN);
    step(); chk_flags("ign_t4_drain", F_DRAIN);
    chk_cnt("ign_t4_cnt", 16'd4);
    chk_pc("ign_t4_pc", 32'h1234_0000);
    step(); chk_flags("ign_t5_idle", F_IDLE);
    chk_cnt("ign_t5_cnt", 16'd4);
    step(); idle_inputs();                    // t6: re-accepted
    chk_flags("ign_t6_commit", F_COMMIT);
    chk_cnt("ign_t6_cnt", 16'd5);
    chk_pc("ign_t6_pc", 32'h9999_0000);
    step(); step(); step(); step();
    chk_flags("ign_end_idle", F_IDLE);
  endtask

  // T5: reset in REDIRECT clears everything immediately
  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h4444_0000; redirect_ready = 1'b0;
    step(); idle_inputs();
    step();
    chk_flags("rmid_in_redirect", F_REDIRECT);
    reset = 1'b1;
    #1;
    chk_flags("rmid_flags", F_IDLE);
    chk_pc("rmid_pc", 32'h0);
    chk_cnt("rmid_cnt", 16'd0);
    chk_ertn("rmid_ertn", 1'b0);
    #1 reset = 1'b0;
    redirect_ready = 1'b1;
    step(); step();
    chk_flags("rmid_stays_idle", F_IDLE);
  endtask

  // T6: CNT_W=2 counter saturates at 3
  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      s_wb_valid = 1'b1;
      step();
      s_wb_valid = 1'b0;
      tests_run++;
      if (s_flush_cnt !== exp_cnt[i]) begin
        tests_failed++;
        $display("FAIL sat_cnt%0d: flush_cnt got %0d expected %0d", i, s_flush_cnt, exp_cnt[i]);
      end
      step(); step(); step(); step();
    end
    tests_run++;
    if (s_wb_block !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_idle: wb_block got %b expected 0", s_wb_block);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_ertn_stall();
    test_both();
    test_ignore();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
